// File: rtl/rr_arb4way16.sv
// rr_arb4way16 - four-channel, 16-bit round-robin arbiter with a one-entry
// registered output stage, feeding a Mux4Way16-style selector.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   a, b, c, d   channel data words (channel index 0..3)
//   in_valid     per-channel request
//   in_ready     per-channel take strobe (combinational, one-hot or zero)
//   out          registered granted word
//   out_valid    out holds an undelivered word
//   out_ready    consumer accepts out this edge
//   sel          registered index of the channel that produced out
//   grant_count  accepted-word counter (zero unless enabled)
//
// Build option: define RR_ARB4WAY16_CNT_EN to enable the wrapping 16-bit
// grant counter; otherwise grant_count is tied to zero.

module rr_arb4way16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [3:0]  in_valid,
  output logic [3:0]  in_ready,
  output logic [15:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  sel,
  output logic [15:0] grant_count
);

  logic [1:0]  last;
  logic [1:0]  win;
  logic [1:0]  idx;
  logic        found;
  logic        load;
  logic        take;
  logic [15:0] win_data;

  // Search starts one past the last grant and wraps; 2-bit arithmetic
  // provides the modulo-4 wrap for free.
  always_comb begin
    win   = last;
    found = 1'b0;
    idx   = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && in_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign load = !out_valid || out_ready;
  // rst_n gates the strobe so nothing looks accepted while reset is held.
  assign take = rst_n && load && found;
  assign in_ready = take ? (4'b0001 << win) : 4'b0000;

  always_comb begin
    case (win)
      2'd0:    win_data = a;
      2'd1:    win_data = b;
      2'd2:    win_data = c;
      default: win_data = d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 16'h0000;
      sel       <= 2'b00;
      out_valid <= 1'b0;
      last      <= 2'b11;
    end else if (take) begin
      out       <= win_data;
      sel       <= win;
      out_valid <= 1'b1;
      last      <= win;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_ARB4WAY16_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_count <= 16'h0000;
    end else if (take) begin
      grant_count <= grant_count + 16'h0001;
    end
  end
`else
  assign grant_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rr_arb4way16.sv
module tb_rr_arb4way16;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b, c, d;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  sel;
  logic [15:0] grant_count;

  rr_arb4way16 dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .in_valid(in_valid), .in_ready(in_ready), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .sel(sel),
    .grant_count(grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_out;
  logic [1:0]  m_sel;
  logic        m_valid;
  int          m_last;
  logic [15:0] m_cnt;
  logic [3:0]  last_ir;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = 16'h0000; m_sel = 2'b00; m_valid = 1'b0; m_last = 3; m_cnt = 16'h0000;
  endtask

  // Winner = valid channel at the smallest rotational distance after m_last.
  function automatic int pick(input logic [3:0] v, input int l);
    int best = -1;
    int bd = 99;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && ((i - l + 7) % 4) < bd) begin
        bd = (i - l + 7) % 4;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [15:0] chan_data(input int i);
    case (i)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef RR_ARB4WAY16_CNT_EN
    return m_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  // Called shortly after a rising edge: drive, compare mid-cycle, advance model.
  task automatic step(input logic [3:0] v, input logic r);
    int w;
    logic [3:0] exp_ir;
    in_valid = v;
    out_ready = r;
    @(negedge clk);
    w = pick(in_valid, m_last);
    exp_ir = 4'b0000;
    if (rst_n && (!m_valid || out_ready) && w >= 0) exp_ir[w] = 1'b1;
    chk("in_ready", {12'h000, in_ready}, {12'h000, exp_ir});
    chk("out", out, m_out);
    chk("sel", {14'h0, sel}, {14'h0, m_sel});
    chk("out_valid", {15'h0, out_valid}, {15'h0, m_valid});
    chk("grant_count", grant_count, exp_cnt());
    last_ir = in_ready;
    @(posedge clk);
    if (rst_n) begin
      if (exp_ir != 4'b0000) begin
        m_out = chan_data(w); m_sel = 2'(w); m_last = w; m_valid = 1'b1; m_cnt = m_cnt + 16'h1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) step(4'b0000, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 4'b0; out_ready = 1'b0;
    a = 16'h1234; b = 16'h9876; c = 16'hAAAA; d = 16'h5555;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    chk("rst_out_valid", {15'h0, out_valid}, 16'h0000);

    // Single request on channel 2
    step(4'b0100, 1'b1);
    chk("single_in_ready", {12'h0, last_ir}, 16'h0004);
    chk("single_out", out, 16'hAAAA);
    chk("single_sel", {14'h0, sel}, 16'h0002);
    chk("single_valid", {15'h0, out_valid}, 16'h0001);
    step(4'b0000, 1'b1);
    chk("drain_valid", {15'h0, out_valid}, 16'h0000);
    chk("drain_out_hold", out, 16'hAAAA);

    // Round robin over four continuously valid channels
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1);
      chk("rr_sel", {14'h0, sel}, 16'(k % 4));
      chk("rr_valid", {15'h0, out_valid}, 16'h0001);
    end
    chk("rr_out_last", out, 16'h1234);

    // Backpressure
    do_reset();
    step(4'b0001, 1'b1);
    chk("bp_load", out, 16'h1234);
    for (int k = 0; k < 4; k++) begin
      step(4'b0010, 1'b0);
      chk("bp_in_ready", {12'h0, last_ir}, 16'h0000);
      chk("bp_out_hold", out, 16'h1234);
      chk("bp_sel_hold", {14'h0, sel}, 16'h0000);
    end
    step(4'b0010, 1'b1);
    chk("bp_release_ir", {12'h0, last_ir}, 16'h0002);
    chk("bp_release_out", out, 16'h9876);

    // Pointer wrap (last=1) and skip
    step(4'b0001, 1'b1);
    chk("wrap_sel", {14'h0, sel}, 16'h0000);
    step(4'b1001, 1'b1);
    chk("skip_sel", {14'h0, sel}, 16'h0003);
    chk("skip_out", out, 16'h5555);

    // Async reset mid-stall
    step(4'b0100, 1'b0);
    in_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out", out, 16'h0000);
    chk("async_valid", {15'h0, out_valid}, 16'h0000);
    chk("async_sel", {14'h0, sel}, 16'h0000);
    chk("async_in_ready", {12'h0, in_ready}, 16'h0000);
    model_reset();
    @(posedge clk); #1;
    step(4'b1111, 1'b1);
    rst_n = 1'b1;
    step(4'b1111, 1'b1);
    chk("post_reset_sel", {14'h0, sel}, 16'h0000);
    chk("post_reset_out", out, 16'h1234);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      step(4'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Counter wrap
    do_reset();
    for (int k = 0; k < 70000; k++) step(4'b0001, 1'b1);
`ifdef RR_ARB4WAY16_CNT_EN
    chk("count_70000", grant_count, 16'd4464);
`else
    chk("count_disabled", grant_count, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
